subcor_stage_arbiter: RTL

//   Shares one 4-latency RNS sub-correction stage (8 digits x 18 bits, fixed-latency, no stall) between two

---
 rtl/subcor_stage_arbiter_if.sv | 50 +++++
 rtl/subcor_stage_arbiter.sv | 147 ++++++++++++++
 2 files changed

// File: rtl/subcor_stage_arbiter_if.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module      : subcor_stage_arbiter_if
// Description : Bundles the two requester ports, the sub-correction stage
//               port and the result port of the stage arbiter.
// Revision    : 1.0 - initial release
// ============================================================================
interface subcor_stage_arbiter_if #(
  parameter int DATA_WIDTH = 18,
  parameter int NUM_DIGITS = 8
);
  localparam int W = DATA_WIDTH * NUM_DIGITS;

  logic         req0_valid;
  logic         req0_ready;
  logic [W-1:0] req0_dig;
  logic [1:0]   req0_sign;
  logic         req1_valid;
  logic         req1_ready;
  logic [W-1:0] req1_dig;
  logic [1:0]   req1_sign;
  logic [W-1:0] stg_dig;
  logic [1:0]   stg_sign;
  logic [W-1:0] stg_res;
  logic         res_valid;
  logic         res_ready;
  logic [W-1:0] res_data;
  logic         res_id;
  logic         busy;

  // Requester / stage-model / consumer side
  modport master (
    output req0_valid, req0_dig, req0_sign,
    output req1_valid, req1_dig, req1_sign,
    output stg_res, res_ready,
    input  req0_ready, req1_ready, stg_dig, stg_sign,
    input  res_valid, res_data, res_id, busy
  );

  // Arbiter side
  modport slave (
    input  req0_valid, req0_dig, req0_sign,
    input  req1_valid, req1_dig, req1_sign,
    input  stg_res, res_ready,
    output req0_ready, req1_ready, stg_dig, stg_sign,
    output res_valid, res_data, res_id, busy
  );
endinterface
`default_nettype wire

// File: rtl/subcor_stage_arbiter.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module      : subcor_stage_arbiter
// Description : Round-robin sharing of one fixed-latency RNS sub-correction
//               stage between two requesters, with owner tracking through the
//               stage and a credit-protected result FIFO.
// Revision    : 1.0 - initial release
// ============================================================================
module subcor_stage_arbiter #(
  parameter int DATA_WIDTH = 18,
  parameter int NUM_DIGITS = 8,
  parameter int LATENCY    = 4,
  parameter int FIFO_DEPTH = 8
) (
  input  logic                  clk,
  input  logic                  rst_n,
  subcor_stage_arbiter_if.slave bus
);
  localparam int W  = DATA_WIDTH * NUM_DIGITS;
  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int CW = $clog2(FIFO_DEPTH + 1);
  localparam logic [CW:0] DEPTH_C = (CW + 1)'(FIFO_DEPTH);

  // Round-robin state: id of the requester granted last. Reset to 1 so that
  // requester 0 wins the first tie.
  logic last_id_q;

  logic [W-1:0] stg_dig_q;
  logic [1:0]   stg_sign_q;

  // Owner tracker, one slot per stage cycle plus the FIFO write slot
  logic [LATENCY:0] trk_vld_q;
  logic [LATENCY:0] trk_id_q;

  // Result FIFO
  logic [W-1:0]          mem_q [FIFO_DEPTH];
  logic [FIFO_DEPTH-1:0] id_mem_q;
  logic [PW-1:0]         wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]         rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]         count_q, count_d;
  logic [CW-1:0]         inflight_q, inflight_d;

  logic          credit_ok;
  logic [CW:0]   credit_sum;
  logic          grant0, grant1;
  logic          ready0, ready1;
  logic          issue, issue_id;
  logic          wr_en, wr_id;
  logic          res_valid, pop;

  // Credits come from registered counters only, so a pop is seen one cycle later
  assign credit_sum = {1'b0, inflight_q} + {1'b0, count_q};
  assign credit_ok  = credit_sum < DEPTH_C;

  assign grant0 = bus.req0_valid & (~bus.req1_valid | last_id_q);
  assign grant1 = bus.req1_valid & (~bus.req0_valid | ~last_id_q);

  // Nothing is accepted while reset is held
  assign ready0 = rst_n & credit_ok & grant0;
  assign ready1 = rst_n & credit_ok & grant1;

  assign issue    = (bus.req0_valid & ready0) | (bus.req1_valid & ready1);
  assign issue_id = bus.req1_valid & ready1;

  assign wr_en = trk_vld_q[LATENCY];
  assign wr_id = trk_id_q[LATENCY];

  assign res_valid = (count_q != '0);
  assign pop       = res_valid & bus.res_ready;

  // Round-robin pointer moves only when a word is actually issued
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)     last_id_q <= 1'b1;
    else if (issue) last_id_q <= issue_id;
  end

  // Stage operand registers load the granted word and otherwise hold
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stg_dig_q  <= '0;
      stg_sign_q <= '0;
    end else if (issue) begin
      stg_dig_q  <= issue_id ? bus.req1_dig  : bus.req0_dig;
      stg_sign_q <= issue_id ? bus.req1_sign : bus.req0_sign;
    end
  end

  // Owner tracker shifts every cycle; clearing it discards whatever is in the stage
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      trk_vld_q <= '0;
      trk_id_q  <= '0;
    end else begin
      trk_vld_q <= {trk_vld_q[LATENCY-1:0], issue};
      trk_id_q  <= {trk_id_q[LATENCY-1:0], issue_id};
    end
  end

  // Next-state for occupancy counters and FIFO pointers
  always_comb begin
    inflight_d = inflight_q;
    count_d    = count_q;
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    if (issue && !wr_en)      inflight_d = inflight_q + CW'(1);
    else if (!issue && wr_en) inflight_d = inflight_q - CW'(1);
    if (wr_en && !pop)        count_d = count_q + CW'(1);
    else if (!wr_en && pop)   count_d = count_q - CW'(1);
    if (wr_en)                wr_ptr_d = wr_ptr_q + PW'(1);
    if (pop)                  rd_ptr_d = rd_ptr_q + PW'(1);
  end

  // Counter and pointer registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      inflight_q <= '0;
      count_q    <= '0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
    end else begin
      inflight_q <= inflight_d;
      count_q    <= count_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
    end
  end

  // FIFO storage; contents are don't-care until written, reads are gated by count
  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem_q[wr_ptr_q]    <= bus.stg_res;
      id_mem_q[wr_ptr_q] <= wr_id;
    end
  end

  assign bus.req0_ready = ready0;
  assign bus.req1_ready = ready1;
  assign bus.stg_dig    = stg_dig_q;
  assign bus.stg_sign   = stg_sign_q;
  assign bus.res_valid  = res_valid;
  assign bus.res_data   = res_valid ? mem_q[rd_ptr_q] : '0;
  assign bus.res_id     = res_valid & id_mem_q[rd_ptr_q];
  assign bus.busy       = (inflight_q != '0) | (count_q != '0);

endmodule
`default_nettype wire
